// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: drives columns active-low in turn, builds a per-frame
// result, debounces it across frames and hands press events to a one-entry buffer.
module keypad_scan_ctrl #(
    parameter int SCAN_TICKS      = 50000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overflow
);
    localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {R_NONE, R_ONE, R_MULTI} res_kind_t;
    typedef enum logic {S_NONE, S_ONE} stable_t;

    function automatic logic [3:0] keymap(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:  code = 4'h1;  4'd1:  code = 4'h4;  4'd2:  code = 4'h7;  4'd3:  code = 4'h0;
            4'd4:  code = 4'h2;  4'd5:  code = 4'h5;  4'd6:  code = 4'h8;  4'd7:  code = 4'hF;
            4'd8:  code = 4'h3;  4'd9:  code = 4'h6;  4'd10: code = 4'h9;  4'd11: code = 4'hE;
            4'd12: code = 4'hA;  4'd13: code = 4'hB;  4'd14: code = 4'hC;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    logic [3:0] row_s1, row_s2;
    logic [TW-1:0] tick;
    logic [1:0] col_idx;
    logic slot_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1  <= 4'hF;
            row_s2  <= 4'hF;
            tick    <= '0;
            col_idx <= 2'd0;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
            tick   <= slot_end ? '0 : tick + 1'b1;
            if (slot_end) col_idx <= col_idx + 2'd1;
        end
    end

    assign slot_end = (tick == TICK_LAST);
    assign col      = ~(4'b1000 >> col_idx);

    // Per-slot decode, merged into a running frame count that saturates at 2 (MULTI).
    logic [3:0] low, slot_code, base_code, merged_code, acc_code;
    logic [1:0] slot_cnt, row_sel, base_cnt, merged_cnt, acc_cnt;
    logic [2:0] sum_cnt;

    always_comb begin
        low = ~row_s2;
        case (low)
            4'b0000:                            slot_cnt = 2'd0;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: slot_cnt = 2'd1;
            default:                            slot_cnt = 2'd2;
        endcase
        if (low[3])      row_sel = 2'd0;
        else if (low[2]) row_sel = 2'd1;
        else if (low[1]) row_sel = 2'd2;
        else             row_sel = 2'd3;
        slot_code   = keymap({col_idx, row_sel});
        base_cnt    = (col_idx == 2'd0) ? 2'd0 : acc_cnt;
        base_code   = (col_idx == 2'd0) ? 4'h0 : acc_code;
        sum_cnt     = {1'b0, base_cnt} + {1'b0, slot_cnt};
        merged_cnt  = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
        merged_code = (base_cnt == 2'd0) ? slot_code : base_code;
    end

    logic frame_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt    <= 2'd0;
            acc_code   <= 4'h0;
            frame_done <= 1'b0;
        end else begin
            if (slot_end) begin
                acc_cnt  <= merged_cnt;
                acc_code <= merged_code;
            end
            frame_done <= slot_end && (col_idx == 2'd3);
        end
    end

    // Debounce: acc_* holds the finished frame during the frame_done cycle.
    res_kind_t res_kind, prev_kind;
    logic [3:0] prev_code, stable_code, stable_code_d, ev_code;
    logic [CW-1:0] db_cnt, cnt_next;
    logic same, ev_next, ev_pend;
    stable_t state_q, state_d;

    always_comb begin
        case (acc_cnt)
            2'd0:    res_kind = R_NONE;
            2'd1:    res_kind = R_ONE;
            default: res_kind = R_MULTI;
        endcase
        same     = (res_kind == prev_kind) && ((res_kind != R_ONE) || (acc_code == prev_code));
        cnt_next = same ? ((db_cnt == CNT_MAX) ? CNT_MAX : db_cnt + 1'b1) : CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_NONE;
            stable_code <= 4'h0;
            prev_kind   <= R_NONE;
            prev_code   <= 4'h0;
            db_cnt      <= '0;
            ev_pend     <= 1'b0;
            ev_code     <= 4'h0;
        end else begin
            state_q     <= state_d;
            stable_code <= stable_code_d;
            ev_pend     <= ev_next;
            ev_code     <= stable_code_d;
            if (frame_done) begin
                prev_kind <= res_kind;
                prev_code <= acc_code;
                db_cnt    <= cnt_next;
            end
        end
    end

    // MULTI never becomes stable; it only restarts the count via cnt_next.
    always_comb begin
        state_d       = state_q;
        stable_code_d = stable_code;
        ev_next       = 1'b0;
        if (frame_done && (cnt_next == CNT_MAX)) begin
            case (res_kind)
                R_NONE: state_d = S_NONE;
                R_ONE: begin
                    if ((state_q == S_NONE) || (acc_code != stable_code)) begin
                        state_d       = S_ONE;
                        stable_code_d = acc_code;
                        ev_next       = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        key_held = (state_q == S_ONE);
    end

    // valid/ready: an event transfers on a cycle with key_valid & key_ready;
    // key_valid/key_code hold until then, and a new event arriving while the
    // buffer is full and not being accepted is dropped with an overflow pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            overflow  <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (ev_pend) begin
                if (!key_valid || key_ready) begin
                    key_valid <= 1'b1;
                    key_code  <= ev_code;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: keypad matrix model, frame-level reference model,
// table of single-key vectors, hand sequences and randomized frames.
module tb_keypad_scan_ctrl;
    localparam int ST    = 8;
    localparam int DF    = 3;
    localparam int FRAME = 4 * ST;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [3:0] row, col, key_code;
    logic key_valid, key_held, overflow;
    logic key_ready = 1'b0;
    logic [15:0] pos = 16'h0;   // pressed matrix positions, bit k*4+r (k column, r = R1..R4)
    logic [3:0] keymap [16];

    always #5 clk = ~clk;

    keypad_scan_ctrl #(.SCAN_TICKS(ST), .DEBOUNCE_FRAMES(DF)) dut (
        .clk(clk), .rst_n(rst_n), .row(row), .col(col),
        .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
        .key_held(key_held), .overflow(overflow)
    );

    // A pressed key shorts its row to its column; rows pull high otherwise.
    always_comb begin
        row = 4'hF;
        for (int k = 0; k < 4; k++)
            for (int r = 0; r < 4; r++)
                if (pos[k*4+r] && !col[3-k]) row[3-r] = 1'b0;
    end

    int checks = 0, failures = 0;
    int n;
    logic exp_valid, exp_ovf, exp_held, held_pend;
    logic [3:0] exp_code, ev_c;
    int hist[$];
    int stable, held_edge, ev_edge;
    int valid_cycles, ovf_cycles, last_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
        end
    endtask

    task automatic model_reset();
        n = 0; exp_valid = 0; exp_code = 0; exp_ovf = 0; exp_held = 0; held_pend = 0;
        hist.delete(); stable = -1; held_edge = -1; ev_edge = -1;
    endtask

    // Frame result from the set of pressed keys: each key is seen exactly once per frame.
    task automatic frame_end();
        int cnt, res, idx;
        bit eq;
        cnt = $countones(pos);
        idx = 0;
        for (int i = 0; i < 16; i++) if (pos[i]) idx = i;
        if (cnt == 0) res = -1;
        else if (cnt == 1) res = int'(keymap[idx]);
        else res = 16;
        hist.push_back(res);
        if (hist.size() > DF) void'(hist.pop_front());
        eq = (hist.size() == DF);
        foreach (hist[i]) if (hist[i] != res) eq = 0;
        if (eq && res != 16 && res != stable) begin
            stable = res;
            held_pend = (res >= 0);
            held_edge = n + 1;
            if (res >= 0) begin
                ev_edge = n + 2;
                ev_c = res[3:0];
            end
        end
    endtask

    task automatic step();
        logic rdy;
        logic [3:0] ec;
        rdy = key_ready;
        if (key_valid && key_ready) last_acc = int'(key_code);
        @(posedge clk);
        n++;
        exp_ovf = 0;
        if (n == held_edge) exp_held = held_pend;
        if (n == ev_edge) begin
            if (!exp_valid || rdy) begin
                exp_valid = 1;
                exp_code = ev_c;
            end else begin
                exp_ovf = 1;
            end
        end else if (exp_valid && rdy) begin
            exp_valid = 0;
        end
        @(negedge clk);
        ec = ~(4'b1000 >> ((n / ST) % 4));
        check("col", col, ec);
        check("key_valid", key_valid, exp_valid);
        check("key_code", key_code, exp_code);
        check("key_held", key_held, exp_held);
        check("overflow", overflow, exp_ovf);
        if (key_valid) valid_cycles++;
        if (overflow) ovf_cycles++;
        if (n % FRAME == 0) frame_end();
    endtask

    task automatic run_frames(input int f);
        repeat (f * FRAME) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_col", col, 4'b0111);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_code", key_code, 0);
        check("rst_key_held", key_held, 0);
        check("rst_overflow", overflow, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        int k;
        int r;
        logic [3:0] exp_code;
    } vec_t;

    vec_t vecs [10];

    initial begin
        keymap = '{4'h1, 4'h4, 4'h7, 4'h0, 4'h2, 4'h5, 4'h8, 4'hF,
                   4'h3, 4'h6, 4'h9, 4'hE, 4'hA, 4'hB, 4'hC, 4'hD};
        vecs[0] = '{0, 0, 4'h1};  vecs[1] = '{0, 3, 4'h0};  vecs[2] = '{1, 3, 4'hF};
        vecs[3] = '{2, 3, 4'hE};  vecs[4] = '{3, 0, 4'hA};  vecs[5] = '{3, 1, 4'hB};
        vecs[6] = '{3, 2, 4'hC};  vecs[7] = '{2, 1, 4'h6};  vecs[8] = '{1, 2, 4'h8};
        vecs[9] = '{0, 2, 4'h7};
        n = 0;
        model_reset();
        @(negedge clk);

        // 1: idle scan
        do_reset();
        valid_cycles = 0; ovf_cycles = 0;
        run_frames(2);
        check("t1_valid_cycles", valid_cycles, 0);
        check("t1_ovf_cycles", ovf_cycles, 0);

        // 2: hold '5' for 6 frames, then release
        key_ready = 1; valid_cycles = 0; last_acc = -1;
        pos = 16'h0020;
        run_frames(6);
        check("t2_valid_cycles", valid_cycles, 1);
        check("t2_code", last_acc, 5);
        check("t2_held", key_held, 1);
        pos = 16'h0;
        run_frames(2);
        check("t2_held_2_empty", key_held, 1);
        run_frames(2);
        check("t2_held_released", key_held, 0);

        // 3: '5' on alternate frames
        valid_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            pos = (i % 2 == 0) ? 16'h0020 : 16'h0;
            run_frames(1);
        end
        check("t3_valid_cycles", valid_cycles, 0);
        check("t3_held", key_held, 0);

        // 4: '1' and '2' together, then release '2'
        pos = 16'h0;
        run_frames(3);
        valid_cycles = 0; ovf_cycles = 0; last_acc = -1;
        pos = 16'h0011;
        run_frames(5);
        check("t4_multi_valid", valid_cycles, 0);
        check("t4_multi_ovf", ovf_cycles, 0);
        pos = 16'h0001;
        run_frames(4);
        check("t4_code", last_acc, 1);

        // 5: consumer stalled; 'A' then 'D'
        pos = 16'h0;
        run_frames(3);
        key_ready = 0; ovf_cycles = 0;
        pos = 16'h1000; run_frames(3);
        pos = 16'h0;    run_frames(3);
        pos = 16'h8000; run_frames(3);
        repeat (4) step();
        check("t5_ovf_cycles", ovf_cycles, 1);
        check("t5_valid_held", key_valid, 1);
        check("t5_code_held", key_code, 4'hA);
        key_ready = 1; step();
        key_ready = 0; step();
        check("t5_valid_after_accept", key_valid, 0);
        check("t5_accepted_code", last_acc, 10);
        while (n % FRAME != 0) step();

        // 6: reset mid C3 slot with an event pending and '9' held
        pos = 16'h0400;
        run_frames(3);
        while (n % FRAME != 2 * ST + 4) step();
        check("t6_valid_before_reset", key_valid, 1);
        do_reset();
        key_ready = 1; valid_cycles = 0; last_acc = -1;
        run_frames(4);
        check("t6_rereport_count", valid_cycles, 1);
        check("t6_rereport_code", last_acc, 9);

        // table: each matrix position maps to its legend
        pos = 16'h0;
        run_frames(3);
        foreach (vecs[i]) begin
            last_acc = -1;
            pos = 16'h0;
            pos[vecs[i].k*4 + vecs[i].r] = 1'b1;
            run_frames(4);
            check($sformatf("vec%0d_code", i), last_acc, vecs[i].exp_code);
            pos = 16'h0;
            run_frames(3);
        end

        // randomized frames and consumer back-pressure
        for (int f = 0; f < 25; f++) begin
            int sel, len;
            sel = $urandom_range(0, 3);
            len = $urandom_range(1, 4);
            if (sel == 0) pos = 16'h0;
            else if (sel == 1) begin
                pos = 16'h0;
                pos[$urandom_range(0, 15)] = 1'b1;
            end else if (sel == 2) begin
                pos = 16'h0;
                pos[$urandom_range(0, 15)] = 1'b1;
                pos[$urandom_range(0, 15)] = 1'b1;
            end
            repeat (len * FRAME) begin
                key_ready = ($urandom_range(0, 3) != 0);
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
